regfile_writer: RTL and testbench



---
 rtl/regfile_writer.sv | 111 +++++++++++
 tb/tb_regfile_writer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/regfile_writer.sv
// Write side of the 32 x 32-bit general-purpose register file.
// One-hot write decode, 31 storage registers, all values presented in parallel; register 0 is constant zero.
module regfile_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] odata1,
  output logic [31:0] odata2,
  output logic [31:0] odata3,
  output logic [31:0] odata4,
  output logic [31:0] odata5,
  output logic [31:0] odata6,
  output logic [31:0] odata7,
  output logic [31:0] odata8,
  output logic [31:0] odata9,
  output logic [31:0] odata10,
  output logic [31:0] odata11,
  output logic [31:0] odata12,
  output logic [31:0] odata13,
  output logic [31:0] odata14,
  output logic [31:0] odata15,
  output logic [31:0] odata16,
  output logic [31:0] odata17,
  output logic [31:0] odata18,
  output logic [31:0] odata19,
  output logic [31:0] odata20,
  output logic [31:0] odata21,
  output logic [31:0] odata22,
  output logic [31:0] odata23,
  output logic [31:0] odata24,
  output logic [31:0] odata25,
  output logic [31:0] odata26,
  output logic [31:0] odata27,
  output logic [31:0] odata28,
  output logic [31:0] odata29,
  output logic [31:0] odata30,
  output logic [31:0] odata31,
  output logic [31:0] odata32,
  output logic        wr_done
);

  logic [31:0] rf_reg [1:31];
  logic [31:1] wen;
  logic        wr_done_reg;
  logic        wr_done_next;

  // Enables exist only for registers 1..31, so a waddr=0 write has nowhere to land.
  // Gating by we first keeps an unknown waddr from reaching any enable while idle.
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : gen_dec
      assign wen[gi] = we && (waddr == 5'(gi));
    end
  endgenerate

  assign wr_done_next = |wen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        rf_reg[i] <= '0;
      end
      wr_done_reg <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wen[i]) begin
          rf_reg[i] <= wdata;
        end
      end
      wr_done_reg <= wr_done_next;
    end
  end

  assign wr_done = wr_done_reg;

  assign odata1  = 32'h0;
  assign odata2  = rf_reg[1];
  assign odata3  = rf_reg[2];
  assign odata4  = rf_reg[3];
  assign odata5  = rf_reg[4];
  assign odata6  = rf_reg[5];
  assign odata7  = rf_reg[6];
  assign odata8  = rf_reg[7];
  assign odata9  = rf_reg[8];
  assign odata10 = rf_reg[9];
  assign odata11 = rf_reg[10];
  assign odata12 = rf_reg[11];
  assign odata13 = rf_reg[12];
  assign odata14 = rf_reg[13];
  assign odata15 = rf_reg[14];
  assign odata16 = rf_reg[15];
  assign odata17 = rf_reg[16];
  assign odata18 = rf_reg[17];
  assign odata19 = rf_reg[18];
  assign odata20 = rf_reg[19];
  assign odata21 = rf_reg[20];
  assign odata22 = rf_reg[21];
  assign odata23 = rf_reg[22];
  assign odata24 = rf_reg[23];
  assign odata25 = rf_reg[24];
  assign odata26 = rf_reg[25];
  assign odata27 = rf_reg[26];
  assign odata28 = rf_reg[27];
  assign odata29 = rf_reg[28];
  assign odata30 = rf_reg[29];
  assign odata31 = rf_reg[30];
  assign odata32 = rf_reg[31];

endmodule

// File: tb/tb_regfile_writer.sv
// Scoreboard bench for regfile_writer: stimulus pushes the expected post-edge state,
// a monitor pops and compares it just after each rising edge.
module tb_regfile_writer;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] odata1, odata2, odata3, odata4, odata5, odata6, odata7, odata8;
  logic [31:0] odata9, odata10, odata11, odata12, odata13, odata14, odata15, odata16;
  logic [31:0] odata17, odata18, odata19, odata20, odata21, odata22, odata23, odata24;
  logic [31:0] odata25, odata26, odata27, odata28, odata29, odata30, odata31, odata32;
  logic        wr_done;

  regfile_writer dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .odata1(odata1), .odata2(odata2), .odata3(odata3), .odata4(odata4),
    .odata5(odata5), .odata6(odata6), .odata7(odata7), .odata8(odata8),
    .odata9(odata9), .odata10(odata10), .odata11(odata11), .odata12(odata12),
    .odata13(odata13), .odata14(odata14), .odata15(odata15), .odata16(odata16),
    .odata17(odata17), .odata18(odata18), .odata19(odata19), .odata20(odata20),
    .odata21(odata21), .odata22(odata22), .odata23(odata23), .odata24(odata24),
    .odata25(odata25), .odata26(odata26), .odata27(odata27), .odata28(odata28),
    .odata29(odata29), .odata30(odata30), .odata31(odata31), .odata32(odata32),
    .wr_done(wr_done)
  );

  // Register k lives in bits [k*32 +: 32]
  logic [1023:0] obs_all;
  assign obs_all = {odata32, odata31, odata30, odata29, odata28, odata27, odata26, odata25,
                    odata24, odata23, odata22, odata21, odata20, odata19, odata18, odata17,
                    odata16, odata15, odata14, odata13, odata12, odata11, odata10, odata9,
                    odata8, odata7, odata6, odata5, odata4, odata3, odata2, odata1};

  typedef struct {
    logic [1023:0] regs;
    logic          done;
    int            id;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          txn_id   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic chk_all(input string name, input logic [1023:0] exp);
    int bad;
    n_checks++;
    bad = -1;
    for (int i = 31; i >= 0; i--) begin
      if (obs_all[i*32 +: 32] !== exp[i*32 +: 32]) bad = i;
    end
    if (bad < 0) n_pass++;
    else $display("FAIL %s: odata%0d got %08h expected %08h", name, bad + 1,
                  obs_all[bad*32 +: 32], exp[bad*32 +: 32]);
  endtask

  function automatic logic [1023:0] model_vec();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  // Drive one edge's worth of stimulus and record what the outputs must look like after it.
  task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    we = w; waddr = a; wdata = d;
    e.done = w && (a != 5'd0);
    if (e.done) model[a] = d;
    e.regs = model_vec();
    e.id   = txn_id++;
    sb_q.push_back(e);
  endtask

  // Monitor: one line per transaction, compares everything just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("txn %0d: we=%0b waddr=%0d wr_done=%0b", e.id, we, waddr, wr_done);
        chk_all($sformatf("txn%0d_regs", e.id), e.regs);
        chk32($sformatf("txn%0d_wr_done", e.id), {31'b0, wr_done}, {31'b0, e.done});
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    #2;
    chk_all("reset_regs", {1024{1'b0}});
    chk32("reset_wr_done", {31'b0, wr_done}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single write to reg 5, then an idle edge so the pulse must drop.
    step(1'b1, 5'd5, 32'hDEADBEEF);
    step(1'b0, 5'd5, 32'h0);
    chk32("single_odata6", odata6, 32'hDEADBEEF);

    // Register 0 write must vanish.
    step(1'b1, 5'd0, 32'hFFFFFFFF);
    step(1'b0, 5'd0, 32'h0);
    chk32("reg0_odata1", odata1, 32'h0);

    // Sweep every writable register on consecutive edges.
    for (int k = 1; k < 32; k++) step(1'b1, 5'(k), 32'h1000_0000 + 32'(k));
    step(1'b0, 5'd0, 32'h0);
    chk32("sweep_odata32", odata32, 32'h1000_001F);
    chk32("sweep_odata2", odata2, 32'h1000_0001);
    chk32("sweep_odata6", odata6, 32'h1000_0005);
    chk32("sweep_odata1", odata1, 32'h0);

    // Idle with noisy address/data.
    for (int i = 0; i < 10; i++) step(1'b0, 5'($urandom), $urandom);

    // Overwrite reg 31 back to back.
    step(1'b1, 5'd31, 32'hA5A5A5A5);
    step(1'b1, 5'd31, 32'h5A5A5A5A);
    step(1'b0, 5'd0, 32'h0);
    chk32("overwrite_odata32", odata32, 32'h5A5A5A5A);

    // Asynchronous reset mid-cycle with a write pending on the next edge.
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678;
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_reset_regs", {1024{1'b0}});
    chk32("async_reset_wr_done", {31'b0, wr_done}, 32'h0);
    @(negedge clk);
    chk32("reset_write_dropped", odata4, 32'h0);
    chk32("reset_write_no_done", {31'b0, wr_done}, 32'h0);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    we = 1'b0;
    rst_n = 1'b1;

    // First edge after release may commit.
    step(1'b1, 5'd7, 32'hCAFE_0007);
    step(1'b0, 5'd0, 32'h0);
    chk32("post_reset_odata8", odata8, 32'hCAFE_0007);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
